// File: rtl/vga_vram_arbiter_if.sv
// CPU-side access port of the VGA VRAM arbiter: a level request held until a
// one-clock acknowledge.
interface vga_vram_arbiter_if;
    // Handshake: the master raises cpu_req with cpu_we/cpu_addr/cpu_wdata stable
    // and holds all of them until it sees cpu_ack=1 for one clock. cpu_rdata is
    // valid only in that cycle. The master drops cpu_req in the cycle after
    // cpu_ack, or keeps it high to start the next transaction.
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Shares one synchronous single-port VRAM between display scanout (absolute priority)
// and a CPU port. Optional macro VGA_VRAM_ARBITER_BLANK_ONLY_EN limits CPU access to blanking.
module vga_vram_arbiter #(
    parameter int H_DIV = 4,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     p_tick,
    input  logic                     video_on,
    input  logic [9:0]               pixel_x,
    input  logic [9:0]               pixel_y,
    vga_vram_arbiter_if.slave        cpu,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [14:0]              ram_addr,
    output logic [7:0]               ram_wdata,
    input  logic [7:0]               ram_rdata,
    output logic [7:0]               pix_data
);

    localparam int          SH       = $clog2(H_DIV);
    localparam logic [9:0]  PIX_MASK = 10'(H_DIV - 1);
    localparam logic [15:0] FB_WORDS = 16'(FB_W * FB_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DATA  = 2'd2
    } cpu_state_t;

    cpu_state_t  state;
    cpu_state_t  state_next;

    logic        disp_need;
    logic [9:0]  x_cell;
    logic [9:0]  y_cell;
    logic [31:0] row_base;
    logic [14:0] disp_addr;
    logic        in_range;
    logic        start_ok;
    logic        issue_cpu;
    logic        finish_cpu;
    logic [1:0]  disp_v;
    logic        txn_rd_ok;

    // Display fetch happens on the first pixel of every replicated cell.
    assign disp_need = p_tick & video_on & ((pixel_x & PIX_MASK) == 10'd0);
    assign x_cell    = pixel_x >> SH;
    assign y_cell    = pixel_y >> SH;
    assign row_base  = {22'd0, y_cell} * FB_W;
    assign disp_addr = 15'(row_base) + {5'd0, x_cell};
    assign in_range  = {1'b0, cpu.cpu_addr} < FB_WORDS;

    // The ack cycle itself is not a start slot: the master still holds the old
    // request there and only drops it one clock later.
`ifdef VGA_VRAM_ARBITER_BLANK_ONLY_EN
    assign start_ok = cpu.cpu_req & ~disp_need & ~cpu.cpu_ack & ~video_on;
`else
    assign start_ok = cpu.cpu_req & ~disp_need & ~cpu.cpu_ack;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (issue_cpu) state_next = S_ISSUE;
            S_ISSUE: state_next = S_DATA;
            S_DATA:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        issue_cpu  = 1'b0;
        finish_cpu = 1'b0;
        case (state)
            S_IDLE:  issue_cpu  = start_ok;
            S_DATA:  finish_cpu = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            disp_v        <= 2'b00;
            pix_data      <= 8'd0;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= 15'd0;
            ram_wdata     <= 8'd0;
            txn_rd_ok     <= 1'b0;
            cpu.cpu_ack   <= 1'b0;
            cpu.cpu_rdata <= 8'd0;
        end else begin
            disp_v <= {disp_v[0], disp_need};
            if (disp_v[1]) begin
                pix_data <= ram_rdata;
            end

            // Out-of-range CPU accesses keep their slot but never strobe the RAM.
            if (disp_need) begin
                ram_en   <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= disp_addr;
            end else if (issue_cpu) begin
                ram_en    <= in_range;
                ram_we    <= cpu.cpu_we;
                ram_addr  <= cpu.cpu_addr;
                ram_wdata <= cpu.cpu_wdata;
            end else begin
                ram_en <= 1'b0;
            end

            if (issue_cpu) begin
                txn_rd_ok <= ~cpu.cpu_we & in_range;
            end

            cpu.cpu_ack   <= finish_cpu;
            cpu.cpu_rdata <= (finish_cpu & txn_rd_ok) ? ram_rdata : 8'd0;
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: table vectors for display addressing, hand sequences for
// CPU timing corners, and randomized traffic checked by a cycle-level reference model.
module tb_vga_vram_arbiter;

    localparam int FB_WORDS = 19200;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_x = 10'd0;
    logic [9:0]  pixel_y = 10'd0;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'd0;
    logic [7:0]  pix_data;

    vga_vram_arbiter_if cpu_bus ();

    vga_vram_arbiter #(.H_DIV(4), .FB_W(160), .FB_H(120)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .p_tick    (p_tick),
        .video_on  (video_on),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .cpu       (cpu_bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .pix_data  (pix_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM with one clock of read latency.
    logic [7:0] mem    [FB_WORDS];
    logic [7:0] shadow [FB_WORDS];

    always @(posedge clk) begin
        if (ram_en === 1'b1 && int'(ram_addr) < FB_WORDS) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int addr;
    } ev_t;

    ev_t        dq[$];
    ev_t        pq[$];
    int         cyc = 0;
    bit         busy = 0;
    int         c_issue, c_ack, c_addr;
    bit         c_we;
    logic [7:0] c_wdata;
    logic [7:0] pix_hold = 8'd0;
    logic       last_ack = 1'b0;
    bit         m_disp, m_cpu, m_need, m_ack_now, m_start;
    int         m_daddr;
    logic [7:0] m_rd;

    always @(negedge clk) begin
        cyc++;
        if (!nrst) begin
            dq.delete();
            pq.delete();
            busy     = 0;
            pix_hold = 8'd0;
            last_ack = 1'b0;
        end else begin
            m_disp = 0; m_cpu = 0; m_ack_now = 0; m_daddr = 0;
            if (dq.size() > 0 && dq[0].due == cyc) begin
                m_disp  = 1;
                m_daddr = dq[0].addr;
                void'(dq.pop_front());
            end
            if (busy && cyc == c_issue && c_addr < FB_WORDS) m_cpu = 1;

            if (m_disp) begin
                check("disp ram_en", {31'd0, ram_en}, 32'd1);
                check("disp ram_we", {31'd0, ram_we}, 32'd0);
                check("disp ram_addr", {17'd0, ram_addr}, m_daddr);
            end else if (m_cpu) begin
                check("cpu ram_en", {31'd0, ram_en}, 32'd1);
                check("cpu ram_we", {31'd0, ram_we}, {31'd0, c_we});
                check("cpu ram_addr", {17'd0, ram_addr}, c_addr);
                if (c_we) check("cpu ram_wdata", {24'd0, ram_wdata}, {24'd0, c_wdata});
            end else begin
                check("idle ram_en", {31'd0, ram_en}, 32'd0);
            end

            if (pq.size() > 0 && pq[0].due == cyc) begin
                pix_hold = shadow[pq[0].addr];
                void'(pq.pop_front());
            end
            check("pix_data", {24'd0, pix_data}, {24'd0, pix_hold});

            if (busy && cyc == c_ack) begin
                m_rd = (c_we || c_addr >= FB_WORDS) ? 8'd0 : shadow[c_addr];
                check("cpu_ack", {31'd0, cpu_bus.cpu_ack}, 32'd1);
                check("cpu_rdata", {24'd0, cpu_bus.cpu_rdata}, {24'd0, m_rd});
                if (c_we && c_addr < FB_WORDS) shadow[c_addr] = c_wdata;
                busy      = 0;
                m_ack_now = 1;
            end else begin
                check("no cpu_ack", {31'd0, cpu_bus.cpu_ack}, 32'd0);
            end

            m_need = p_tick && video_on && (int'(pixel_x) % 4 == 0);
            if (m_need) begin
                m_daddr = (int'(pixel_y) / 4) * 160 + int'(pixel_x) / 4;
                dq.push_back('{due: cyc + 1, addr: m_daddr});
                pq.push_back('{due: cyc + 3, addr: m_daddr});
            end

            m_start = !busy && !m_ack_now && cpu_bus.cpu_req && !m_need;
`ifdef VGA_VRAM_ARBITER_BLANK_ONLY_EN
            m_start = m_start && !video_on;
`endif
            if (m_start) begin
                busy    = 1;
                c_issue = cyc + 1;
                c_ack   = cyc + 3;
                c_we    = cpu_bus.cpu_we;
                c_addr  = int'(cpu_bus.cpu_addr);
                c_wdata = cpu_bus.cpu_wdata;
            end
            last_ack = cpu_bus.cpu_ack;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic cpu_txn(input bit we, input logic [14:0] addr, input logic [7:0] wd,
                           input bit with_disp, output int lat, output logic [7:0] rd,
                           output int en_cnt, output logic [24:0] op1);
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_wdata = wd;
        if (with_disp) begin
            p_tick = 1'b1; video_on = 1'b1; pixel_x = 10'd0; pixel_y = 10'd0;
        end
        lat = -1; rd = 8'd0; en_cnt = 0; op1 = 25'd0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            p_tick = 1'b0; video_on = 1'b0;
            @(negedge clk);
            if (k == 1) op1 = {ram_en, ram_we, ram_addr, ram_wdata};
            if (ram_en === 1'b1) en_cnt++;
            if (cpu_bus.cpu_ack === 1'b1) begin
                lat = k;
                rd  = cpu_bus.cpu_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_bus.cpu_req = 1'b0;
    endtask

    typedef struct {
        logic       vid;
        int         px;
        int         py;
        logic       exp_en;
        int         exp_addr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, en_cnt, first, second, acks, wait_cnt, max_wait;
        logic [7:0] rd;
        logic [24:0] op1;

        cpu_bus.cpu_req = 1'b0; cpu_bus.cpu_we = 1'b0;
        cpu_bus.cpu_addr = 15'd0; cpu_bus.cpu_wdata = 8'd0;
        for (int i = 0; i < FB_WORDS; i++) begin
            mem[i]    = 8'($urandom);
            shadow[i] = mem[i];
        end
        mem[162] = 8'h5A; shadow[162] = 8'h5A;

        vecs[0] = '{1'b1,   8,   4, 1'b1,   162};
        vecs[1] = '{1'b1,   0,   0, 1'b1,     0};
        vecs[2] = '{1'b1,   4,   0, 1'b1,     1};
        vecs[3] = '{1'b1,  12,   8, 1'b1,   323};
        vecs[4] = '{1'b1, 636, 479, 1'b1, 19199};
        vecs[5] = '{1'b1, 639, 479, 1'b0,     0};
        vecs[6] = '{1'b1,   2,   0, 1'b0,     0};
        vecs[7] = '{1'b0,   8,   4, 1'b0,     0};
        vecs[8] = '{1'b1, 100, 200, 1'b1,  8025};

        // reset state
        #1;
        check("rst ram_en", {31'd0, ram_en}, 0);
        check("rst ram_addr", {17'd0, ram_addr}, 0);
        check("rst ram_wdata", {24'd0, ram_wdata}, 0);
        check("rst cpu_ack", {31'd0, cpu_bus.cpu_ack}, 0);
        check("rst pix_data", {24'd0, pix_data}, 0);
        @(posedge clk); @(posedge clk); #1;
        nrst = 1'b1;

        // display fetch at (8,4): word 162 appears on pix_data three clocks later
        @(posedge clk); #1;
        video_on = 1'b1; p_tick = 1'b1; pixel_x = 10'd8; pixel_y = 10'd4;
        @(posedge clk); #1; p_tick = 1'b0;
        @(negedge clk);
        check("s1 ram_addr", {17'd0, ram_addr}, 162);
        @(negedge clk);
        check("s1 ram_rdata", {24'd0, ram_rdata}, 32'h5A);
        @(negedge clk);
        check("s1 pix_data", {24'd0, pix_data}, 32'h5A);
        repeat (3) @(negedge clk);
        check("s1 pix hold", {24'd0, pix_data}, 32'h5A);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            video_on = vecs[i].vid; p_tick = 1'b1;
            pixel_x = 10'(vecs[i].px); pixel_y = 10'(vecs[i].py);
            @(posedge clk); #1; p_tick = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d ram_en", i), {31'd0, ram_en}, {31'd0, vecs[i].exp_en});
            if (vecs[i].exp_en) check($sformatf("vec%0d ram_addr", i), {17'd0, ram_addr}, vecs[i].exp_addr);
        end
        @(posedge clk); #1;
        video_on = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // CPU write during blanking
        cpu_txn(1'b1, 15'd100, 8'h3C, 1'b0, lat, rd, en_cnt, op1);
        check("s2 issue op", {7'd0, op1}, {7'd0, 1'b1, 1'b1, 15'd100, 8'h3C});
        check("s2 ack latency", lat, 3);
        cpu_txn(1'b0, 15'd100, 8'h00, 1'b0, lat, rd, en_cnt, op1);
        check("readback latency", lat, 3);
        check("readback data", {24'd0, rd}, 32'h3C);

        // CPU read colliding with a display fetch is pushed one clock
        cpu_txn(1'b0, 15'd7, 8'h00, 1'b1, lat, rd, en_cnt, op1);
        check("s3 ack latency", lat, 4);
        check("s3 rdata", {24'd0, rd}, {24'd0, shadow[7]});
        check("s3 ram ops", en_cnt, 2);

        // out-of-range read
        cpu_txn(1'b0, 15'd19200, 8'h00, 1'b0, lat, rd, en_cnt, op1);
        check("s4 ack latency", lat, 3);
        check("s4 rdata", {24'd0, rd}, 0);
        check("s4 ram_en count", en_cnt, 0);

        // back-to-back with the request held through the ack
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 15'd20;
        first = -1; second = -1;
        for (int k = 1; k <= 20 && second < 0; k++) begin
            @(negedge clk);
            if (cpu_bus.cpu_ack === 1'b1) begin
                if (first < 0) first = k;
                else           second = k;
            end
            @(posedge clk); #1;
        end
        cpu_bus.cpu_req = 1'b0;
        check("b2b first ack", first, 4);
        check("b2b ack gap", second - first, 4);
        repeat (4) @(posedge clk);
        #1;

        // reset while the CPU op is in its issue cycle
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 15'd9;
        @(posedge clk); #2;
        nrst = 1'b0;
        #1;
        check("s5 ram_en", {31'd0, ram_en}, 0);
        check("s5 ram_we", {31'd0, ram_we}, 0);
        check("s5 ram_addr", {17'd0, ram_addr}, 0);
        check("s5 cpu_ack", {31'd0, cpu_bus.cpu_ack}, 0);
        check("s5 cpu_rdata", {24'd0, cpu_bus.cpu_rdata}, 0);
        check("s5 pix_data", {24'd0, pix_data}, 0);
        cpu_bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        acks = 0;
        repeat (6) begin
          @(negedge clk);
          if (cpu_bus.cpu_ack === 1'b1) acks++;
        end
        check("s5 aborted ack", acks, 0);
        @(posedge clk); #1;
        cpu_txn(1'b0, 15'd9, 8'h00, 1'b0, lat, rd, en_cnt, op1);
        check("s5 retry latency", lat, 3);
        check("s5 retry rdata", {24'd0, rd}, {24'd0, shadow[9]});

`ifdef VGA_VRAM_ARBITER_BLANK_ONLY_EN
        // request held through active video waits for blanking
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 15'd30;
        video_on = 1'b1; p_tick = 1'b0;
        acks = 0; en_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (cpu_bus.cpu_ack === 1'b1) acks++;
            if (ram_en === 1'b1) en_cnt++;
            @(posedge clk); #1;
        end
        check("s6 no ack in video", acks, 0);
        check("s6 no op in video", en_cnt, 0);
        video_on = 1'b0;
        cpu_txn(1'b0, 15'd30, 8'h00, 1'b0, lat, rd, en_cnt, op1);
        check("s6 ack latency", lat, 3);
        check("s6 rdata", {24'd0, rd}, {24'd0, shadow[30]});
`endif

        // randomized traffic against the reference model
        video_on = 1'b1; wait_cnt = 0; max_wait = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            p_tick  = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 63) == 0) video_on = ~video_on;
            pixel_x = 10'($urandom_range(0, 639));
            pixel_y = 10'($urandom_range(0, 479));
            if (last_ack === 1'b1) begin
                if ($urandom_range(0, 3) != 0) cpu_bus.cpu_req = 1'b0;
                wait_cnt = 0;
            end else if (!cpu_bus.cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_bus.cpu_req   = 1'b1;
                cpu_bus.cpu_we    = 1'($urandom_range(0, 1));
                cpu_bus.cpu_addr  = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(19200, 32767))
                                                                : 15'($urandom_range(0, 19199));
                cpu_bus.cpu_wdata = 8'($urandom);
                wait_cnt = 0;
            end
            if (cpu_bus.cpu_req) begin
                wait_cnt++;
                if (wait_cnt > max_wait) max_wait = wait_cnt;
            end
        end
        @(posedge clk); #1;
        if (last_ack !== 1'b1) begin
            // let an in-flight transaction finish before releasing the request
            for (int k = 0; k < 400 && cpu_bus.cpu_req; k++) begin
                @(negedge clk);
                if (cpu_bus.cpu_ack === 1'b1) begin
                    @(posedge clk); #1;
                    cpu_bus.cpu_req = 1'b0;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        cpu_bus.cpu_req = 1'b0; p_tick = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("max cpu wait bounded", {31'd0, max_wait <= 200}, 1);
        check("model drained", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_vram_arbiter.md
VGA_VRAM_ARBITER -- requirements
Module: vga_vram_arbiter

Interface
- REQ-001 SHALL have parameters:
  - H_DIV, default 4: horizontal/vertical pixel replication factor, power of two.
  - FB_W, default 160: framebuffer width in words.
  - FB_H, default 120: framebuffer height in words.
- REQ-002 SHALL have these ports, clock and reset first:
  - clk  in  1  system clock.
  - nrst  in  1  reset, asynchronous, active-low.
  - p_tick  in  1  pixel strobe from the VGA timing block.
  - video_on  in  1  active-area flag from the timing block.
  - pixel_x  in  10  current horizontal pixel.
  - pixel_y  in  10  current vertical pixel.
  - cpu_req  in  1  CPU access request, level, held until ack.
  - cpu_we  in  1  1 = write, 0 = read.
  - cpu_addr  in  15  linear word address.
  - cpu_wdata  in  8  write data.
  - cpu_ack  out  1  one-clk completion pulse.
  - cpu_rdata  out  8  read data, valid while cpu_ack=1.
  - ram_en  out  1  registered RAM strobe.
  - ram_we  out  1  registered RAM write enable.
  - ram_addr  out  15  registered RAM address.
  - ram_wdata  out  8  registered RAM write data.
  - ram_rdata  in  8  synchronous RAM read data, 1-clk latency.
  - pix_data  out  8  registered display word.

Function
- REQ-003 SHALL share one single-port synchronous VRAM between display scanout and a CPU port, issuing at most one RAM operation per clk.
- REQ-004 SHALL define disp_need = p_tick & video_on & (pixel_x mod H_DIV == 0).
- REQ-005 SHALL compute disp_addr = (pixel_y/H_DIV)*FB_W + pixel_x/H_DIV, using shifts for the divides and a full 15-bit result.
- REQ-006 Display SHALL have absolute priority: disp_need in cycle T → ram_en=1, ram_we=0, ram_addr=disp_addr in T+1.
- REQ-007 Display read data SHALL be captured into pix_data at the end of T+2, so it is visible in T+3 (3-clk latency), tracked by a 2-stage display-valid shift register.
- REQ-008 pix_data SHALL hold its value between display fetches; blanking is the consumer's job.
- REQ-009 CPU FSM states and transitions:
  - IDLE → ISSUE when cpu_req=1 and disp_need=0 in cycle T; the RAM op (cpu_we, cpu_addr, cpu_wdata) is presented in T+1.
  - ISSUE → DATA unconditionally.
  - DATA → IDLE with cpu_ack=1 for exactly one clk in T+3; cpu_rdata = ram_rdata for reads, 0 for writes.
- REQ-010 A CPU request blocked by disp_need SHALL stay in IDLE and retry the next clk; no starvation, since display consumes at most one clk in 2*H_DIV.
- REQ-011 Only one CPU transaction SHALL be outstanding; cpu_req sampled in DATA or ISSUE SHALL be ignored until the FSM returns to IDLE.
- REQ-012 Back-to-back: cpu_req still high in the clk after cpu_ack SHALL start a new transaction from IDLE.
- REQ-013 cpu_addr ≥ FB_W*FB_H SHALL follow the full FSM timing with ram_en=0 in the issue slot, write discarded, cpu_rdata=0, ack still at T+3.
- REQ-014 ram_en SHALL be 0 in every clk with no display or CPU operation; ram_we/ram_addr/ram_wdata are don't-care when ram_en=0.

Reset
- REQ-015 nrst low SHALL asynchronously force: FSM=IDLE, display-valid pipe=0, cpu_ack=0, cpu_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, pix_data=0.
- REQ-016 Reset mid-transaction SHALL abort it with no ack; the first operation after release is evaluated in the first clk with nrst high.

Configuration
- REQ-017 Macro VGA_VRAM_ARBITER_BLANK_ONLY_EN:
  - Defined: the IDLE→ISSUE transition additionally requires video_on=0, so CPU accesses occur only during blanking.
  - Undefined: CPU accesses are interleaved in any non-display slot per REQ-009.

Verification
- REQ-018 Scenario 1: video_on=1, pixel_x=8, pixel_y=4, p_tick=1 for one clk → T+1 ram_en=1, ram_we=0, ram_addr=162; ram_rdata=0x5A in T+2 → pix_data=0x5A in T+3.
- REQ-019 Scenario 2: video_on=0, cpu_req=1, cpu_we=1, cpu_addr=100, cpu_wdata=0x3C → T+1 ram_en=1, ram_we=1, ram_addr=100, ram_wdata=0x3C; cpu_ack=1 only in T+3.
- REQ-020 Scenario 3: cpu_req=1 (read, addr 7) and disp_need=1 in the same clk → display issued T+1, CPU issued T+2, cpu_ack in T+4 with cpu_rdata=RAM[7].
- REQ-021 Scenario 4: cpu_addr=19200 read → ram_en stays 0 throughout, cpu_ack at T+3, cpu_rdata=0.
- REQ-022 Scenario 5: nrst pulsed low in ISSUE → no cpu_ack, all outputs 0; re-request completes normally.
- REQ-023 Scenario 6 (BLANK_ONLY_EN defined): cpu_req held while video_on=1 → no CPU op until the first clk with video_on=0, then ack 3 clk later.
